// File: rtl/vec_issue_pkg.sv
// Shared types and opcode constants for the scalar-side vector issue queue.
// The entry width is fixed here by XLEN.
package vec_issue_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] V_ARITH = 7'h57;
   localparam logic [6:0] V_LOAD  = 7'h07;
   localparam logic [6:0] V_STORE = 7'h27;
   localparam logic [2:0] CONF    = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
   } vec_issue_entry_t;

   typedef enum logic {
      ISSUE    = 1'b0,
      CFG_WAIT = 1'b1
   } issue_state_e;

   function automatic logic is_vec_op(input logic [XLEN-1:0] inst);
      return (inst[6:0] == V_ARITH) || (inst[6:0] == V_LOAD) || (inst[6:0] == V_STORE);
   endfunction

   function automatic logic is_cfg_op(input logic [XLEN-1:0] inst);
      return (inst[6:0] == V_ARITH) && (inst[14:12] == CONF);
   endfunction

endpackage

// File: rtl/vec_issue_queue_if.sv
// Scalar-side and vector-side handshake bundle of the issue queue.
// The master modport is the environment; the slave modport is the queue itself.
interface vec_issue_queue_if
   import vec_issue_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            s_valid;
   logic [XLEN-1:0] s_inst;
   logic [XLEN-1:0] s_rs1_data;
   logic [XLEN-1:0] s_rs2_data;
   logic            s_is_vec;
   logic            s_ready;
   logic            flush;
   logic            v_valid;
   logic [XLEN-1:0] v_inst;
   logic [XLEN-1:0] v_rs1_data;
   logic [XLEN-1:0] v_rs2_data;
   logic            v_is_vec;
   logic            v_ready;
   logic            cfg_done;
   logic [CW-1:0]   count;
   logic            cfg_pending;

   modport master (
      output s_valid, s_inst, s_rs1_data, s_rs2_data, flush, v_ready, cfg_done,
      input  s_is_vec, s_ready, v_valid, v_inst, v_rs1_data, v_rs2_data, v_is_vec,
             count, cfg_pending
   );

   modport slave (
      input  s_valid, s_inst, s_rs1_data, s_rs2_data, flush, v_ready, cfg_done,
      output s_is_vec, s_ready, v_valid, v_inst, v_rs1_data, v_rs2_data, v_is_vec,
             count, cfg_pending
   );

endinterface

// File: rtl/vec_issue_fifo.sv
// In-order entry FIFO; head read combinationally from storage, writes land next cycle.
// Caller must not push when full or pop when empty; flush clears pointers and count.
module vec_issue_fifo
   import vec_issue_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       push,
   input  vec_issue_entry_t           wr_dat,
   input  logic                       pop,
   input  logic                       flush,
   output vec_issue_entry_t           rd_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   vec_issue_entry_t mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage is reset so the head reads zero straight out of reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !flush) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   assign rd_dat = mem[rd_ptr];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

endmodule

// File: rtl/vec_issue_queue.sv
// Vector issue queue: classify, buffer in order, hold younger issue behind vset* until cfg_done.
// Latency 1 cycle (0 with VEC_ISSUE_BYPASS_EN on an empty queue); s_ready drops when full or flushing.
module vec_issue_queue
   import vec_issue_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                    clk,
   input  logic                    n_rst,
   vec_issue_queue_if.slave        issue
);
   localparam int CW = $clog2(DEPTH) + 1;

   issue_state_e     state;
   issue_state_e     state_nxt;
   logic             issue_en;
   logic             pending;

   vec_issue_entry_t s_ent;
   vec_issue_entry_t fifo_head;
   vec_issue_entry_t head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CW-1:0]    fifo_count;
   logic             push_req;
   logic             fire;
   logic             byp;

   assign s_ent = '{inst: issue.s_inst, rs1_data: issue.s_rs1_data, rs2_data: issue.s_rs2_data};

   assign issue.s_is_vec = is_vec_op(issue.s_inst);
   assign issue.s_ready  = !fifo_full && !issue.flush;
   assign push_req       = issue.s_valid && issue.s_is_vec && issue.s_ready;

`ifdef VEC_ISSUE_BYPASS_EN
   assign byp = fifo_empty && issue_en && !issue.flush && issue.s_valid && issue.s_is_vec;
`else
   assign byp = 1'b0;
`endif

   assign head = byp ? s_ent : fifo_head;
   assign fire = issue.v_valid && issue.v_ready && !issue.flush;

   // A bypassed entry that is accepted immediately never touches storage.
   assign fifo_push = push_req && !(byp && issue.v_ready);
   assign fifo_pop  = fire && !byp;

   vec_issue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .n_rst  (n_rst),
      .push   (fifo_push),
      .wr_dat (s_ent),
      .pop    (fifo_pop),
      .flush  (issue.flush),
      .rd_dat (fifo_head),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= ISSUE;
      end else begin
         state <= state_nxt;
      end
   end

   // cfg_done outside CFG_WAIT is stale and simply dropped.
   always_comb begin
      state_nxt = state;
      if (issue.flush) begin
         state_nxt = ISSUE;
      end else begin
         case (state)
            ISSUE:    if (fire && is_cfg_op(head.inst)) state_nxt = CFG_WAIT;
            CFG_WAIT: if (issue.cfg_done)                state_nxt = ISSUE;
            default:  state_nxt = ISSUE;
         endcase
      end
   end

   always_comb begin
      issue_en = 1'b0;
      pending  = 1'b0;
      case (state)
         ISSUE:    issue_en = 1'b1;
         CFG_WAIT: pending  = 1'b1;
         default:  issue_en = 1'b0;
      endcase
   end

   assign issue.v_valid     = (issue_en && !fifo_empty) || byp;
   assign issue.v_is_vec    = issue.v_valid;
   assign issue.v_inst      = head.inst;
   assign issue.v_rs1_data  = head.rs1_data;
   assign issue.v_rs2_data  = head.rs2_data;
   assign issue.count       = fifo_count;
   assign issue.cfg_pending = pending;

endmodule

// File: doc/vec_issue_queue.md
Name: vec_issue_queue

Overview:
- Scalar-side issue stage that feeds vector instructions to vec_decode.
- Accepts {instruction, rs1_data, rs2_data} from the scalar pipeline, classifies the word as vector or not, and buffers it in an in-order FIFO.
- Presents the head entry to the vector unit over a valid/ready handshake.
- Serialises vector configuration (vset*) so no younger vector instruction issues until the CSR update is acknowledged.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, instruction and scalar operand width.

Ports:
- clk  input  1  clock.
- n_rst  input  1  asynchronous active-low reset.
- s_valid  input  1  scalar offers an instruction.
- s_inst  input  XLEN  instruction word.
- s_rs1_data  input  XLEN  rs1 operand.
- s_rs2_data  input  XLEN  rs2 operand.
- s_is_vec  output  1  combinational: s_inst[6:0] is 0x57, 0x07 or 0x27.
- s_ready  output  1  queue can accept.
- flush  input  1  discard all queued entries and cancel CFG_WAIT.
- v_valid  output  1  head entry valid.
- v_inst  output  XLEN  head instruction.
- v_rs1_data  output  XLEN  head rs1.
- v_rs2_data  output  XLEN  head rs2.
- v_is_vec  output  1  qualifies the decoder; equals v_valid.
- v_ready  input  1  vector unit accepts the head.
- cfg_done  input  1  one-cycle pulse: vtype/vl written.
- count  output  $clog2(DEPTH)+1  occupancy.
- cfg_pending  output  1  high while in CFG_WAIT.

Behaviour:
- Reset (async, n_rst=0):
  - pointers and count go to 0; state goes to ISSUE.
  - v_valid=0, v_inst/v_rs1_data/v_rs2_data=0, cfg_pending=0.
  - s_ready is 1 after the reset edge.
- Push:
  - Occurs when s_valid && s_ready && s_is_vec.
  - s_valid with !s_is_vec is ignored: no push, no error.
  - s_ready = !full && !flush.
- Pop:
  - Occurs when v_valid && v_ready.
  - v_valid = !empty && state==ISSUE.
  - Outputs come from the FIFO storage at the read pointer. The head is stable while v_valid && !v_ready.
- Latency: a push in cycle N gives earliest v_valid in cycle N+1.
- Simultaneous push and pop:
  - When not full, both occur and count is unchanged.
  - When full, push is refused (s_ready=0) even if a pop occurs in the same cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by count, not pointer equality.
- Config detect: the head is a vset* when opcode==0x57 and funct3==3'b111.
- FSM:
  - ISSUE: normal issue. A pop of a vset* moves to CFG_WAIT.
  - CFG_WAIT: v_valid forced 0; pushes are still accepted. cfg_done moves to ISSUE.
  - Any state: flush moves to ISSUE.
  - cfg_done received in ISSUE is ignored.
  - A vset* popped in the same cycle as cfg_done for a previous config enters CFG_WAIT; the new pop has priority.
- Flush:
  - Registered. Next cycle count=0, pointers=0, state=ISSUE.
  - A push or pop in the flush cycle is suppressed: s_ready=0 and the pop is not counted.
- Reset mid-operation: all entries are lost and there is no recovery. The scalar side reissues.

Optional Feature:
- Macro: VEC_ISSUE_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state==ISSUE and flush==0, a pushed entry drives v_* combinationally in the same cycle.
  - If v_ready is also high, the entry is consumed without being written to storage; count is unchanged. A bypassed vset* still enters CFG_WAIT.
  - If v_ready is low, the entry is written to storage and presented from storage the next cycle.
- Undefined: 1-cycle minimum latency as above; no combinational path from s_* to v_*.

Decomposition:
- Shared package vec_issue_pkg (or the existing vec_de_csr_defs) holds:
  - opcode constants V_ARITH=7'h57, V_LOAD=7'h07, V_STORE=7'h27.
  - funct3 constant CONF=3'b111.
  - typedef vec_issue_entry_t {inst, rs1_data, rs2_data}.
  - enum issue_state_e {ISSUE, CFG_WAIT}.
- Sub-module vec_issue_fifo: generic synchronous FIFO of vec_issue_entry_t with push, pop, flush and count. The top holds classification, FSM and bypass.

Test Plan:
- Basic issue: push vadd.vv v1,v2,v3 = 0x022180D7, rs1=0x11, rs2=0x22, with v_ready=1 → next cycle v_valid=1, v_inst=0x022180D7, v_rs1_data=0x11; count returns to 0 after the pop.
- Non-vector: push 0x00000013 (addi) → s_is_vec=0, count stays 0, v_valid stays 0.
- Backpressure: v_ready=0, push 5 vector instructions into DEPTH=4 → s_ready=0 after the 4th push and the 5th is not accepted; release v_ready → the 4 pop in push order, each held stable while stalled.
- Config: vsetvli x5,x10,e32,m1 = 0x010572D7, then vadd → after the vset* pops, cfg_pending=1 and v_valid=0 for 3 cycles; pulse cfg_done → vadd issues the next cycle.
- Flush in CFG_WAIT with 2 queued entries → next cycle count=0, cfg_pending=0, v_valid=0. Also assert n_rst mid-stream → all outputs 0 immediately, without waiting for a clock edge.
- With VEC_ISSUE_BYPASS_EN, empty queue, s_valid and v_ready both high → v_valid=1 and v_inst=s_inst in the same cycle, count stays 0.
